dmem_resp: RTL

Data-memory responder for the five-stage RISC-V core: the slave end of the core's memory-stage interface (address, store data, write strobe, access size in, load data out). It holds a word-organised RAM with byte-lane writes and RV32 load extension, and flags misaligned or out-of-range accesses. It also provides an optional memory-mapped console port that buffers stored bytes in a small FIFO behind a valid/ready handshake.

---
 rtl/dmem_resp.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_resp.sv
// Data-memory responder for the M stage: byte-lane RAM, RV32 load extension, access error flags.
// Define DMEM_CONSOLE_EN to add the memory-mapped console FIFO at CONSOLE_ADDR.
module dmem_resp #(
    parameter int unsigned MEM_WORDS    = 4096,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [31:0] CONSOLE_ADDR = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addrM,
    input  logic [31:0] writedataM,
    input  logic        memwriteM,
    input  logic        memreadM,
    input  logic [2:0]  memsizeM,
    output logic [31:0] readdataM,
    output logic        misalignM,
    output logic        err,
    output logic [31:0] store_cnt,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        con_full
);
    localparam int unsigned WA = $clog2(MEM_WORDS);
    localparam int unsigned BA = WA + 2;

    logic          active;
    logic          isLoad;
    logic          isStore;
    logic          legalSize;
    logic          misaligned;
    logic          inRam;
    logic          isCon;
    logic          outOfRange;
    logic          accessOk;
    logic          ramWrite;
    logic          pushDrop;
    logic [31:0]   conStatus;
    logic [WA-1:0] wordIdx;

    // A store wins over a simultaneous load.
    assign active  = memreadM | memwriteM;
    assign isStore = memwriteM;
    assign isLoad  = memreadM & ~memwriteM;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        legalSize  = 1'b0;
        misaligned = 1'b0;
        case (memsizeM)
            3'b000: legalSize = 1'b1;
            3'b001: begin
                legalSize  = 1'b1;
                misaligned = addrM[0];
            end
            3'b010: begin
                legalSize  = 1'b1;
                misaligned = |addrM[1:0];
            end
            3'b100: legalSize = ~isStore;
            3'b101: begin
                legalSize  = ~isStore;
                misaligned = addrM[0];
            end
            default: ;
        endcase
    end

    assign misalignM  = active & (~legalSize | misaligned);
    assign inRam      = (addrM >> BA) == 32'd0;
    assign outOfRange = ~inRam & ~isCon;
    assign accessOk   = active & ~misalignM & ~outOfRange;
    assign wordIdx    = addrM[BA-1:2];

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] word;
    logic [7:0]  ldByte;
    logic [15:0] ldHalf;

    assign word   = mem[wordIdx];
    assign ldHalf = addrM[1] ? word[31:16] : word[15:0];

    always_comb begin
        ldByte = word[7:0];
        case (addrM[1:0])
            2'b01:   ldByte = word[15:8];
            2'b10:   ldByte = word[23:16];
            2'b11:   ldByte = word[31:24];
            default: ;
        endcase
    end

    always_comb begin
        readdataM = '0;
        if (isLoad && accessOk) begin
            if (isCon) begin
                readdataM = conStatus;
            end else begin
                case (memsizeM)
                    3'b000:  readdataM = {{24{ldByte[7]}}, ldByte};
                    3'b001:  readdataM = {{16{ldHalf[15]}}, ldHalf};
                    3'b010:  readdataM = word;
                    3'b100:  readdataM = {24'd0, ldByte};
                    3'b101:  readdataM = {16'd0, ldHalf};
                    default: readdataM = '0;
                endcase
            end
        end
    end

    logic [3:0]  laneEn;
    logic [31:0] laneData;

    // Store data is replicated across lanes so each enabled lane picks its own copy.
    always_comb begin
        laneEn   = '0;
        laneData = writedataM;
        case (memsizeM[1:0])
            2'b00: begin
                laneEn   = 4'b0001 << addrM[1:0];
                laneData = {4{writedataM[7:0]}};
            end
            2'b01: begin
                laneEn   = addrM[1] ? 4'b1100 : 4'b0011;
                laneData = {2{writedataM[15:0]}};
            end
            2'b10:   laneEn = 4'b1111;
            default: ;
        endcase
    end

    assign ramWrite = isStore & accessOk & ~isCon;

    // NOTE: the RAM array has no reset; clearing thousands of words would cost a reset tree for no benefit.
    always_ff @(posedge clk) begin
        if (ramWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (laneEn[i]) mem[wordIdx][8*i +: 8] <= laneData[8*i +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err       <= 1'b0;
            store_cnt <= '0;
        end else begin
            if (misalignM || (active && outOfRange) || pushDrop) err <= 1'b1;
            if (ramWrite) store_cnt <= store_cnt + 32'd1;
        end
    end

`ifdef DMEM_CONSOLE_EN
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

    logic [7:0]    fifoMem [FIFO_DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [PW:0]   count;
    logic          push;
    logic          pop;
    logic          pushOk;

    assign isCon     = (addrM == CONSOLE_ADDR);
    assign push      = isStore & accessOk & isCon;
    assign pop       = con_valid & con_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign pushOk    = push & (~con_full | pop);
    assign pushDrop  = push & ~pushOk;
    assign con_valid = (count != '0);
    assign con_full  = (count == FULL_COUNT);
    assign con_data  = con_valid ? fifoMem[rdPtr] : 8'h00;
    assign conStatus = {{(31-PW){1'b0}}, count};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            count <= count + {{PW{1'b0}}, pushOk} - {{PW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk) fifoMem[wrPtr] <= writedataM[7:0];
    end
`else
    logic unusedConsole;

    assign isCon         = 1'b0;
    assign pushDrop      = 1'b0;
    assign conStatus     = '0;
    assign con_valid     = 1'b0;
    assign con_data      = 8'h00;
    assign con_full      = 1'b0;
    assign unusedConsole = ^{con_ready, CONSOLE_ADDR, FIFO_DEPTH};
`endif

endmodule
